flash_read_cache: RTL and testbench

//  Direct-mapped, read-only line cache between the CPU instruction/data read port and the
//  mem_axi read port of flash_controller. Hits return in 2 cycles with no QSPI traffic;

---
 rtl/flash_read_cache_pkg.sv | 45 ++++
 rtl/flash_read_cache_if.sv | 22 ++
 rtl/flash_read_cache_ram.sv | 35 +++
 rtl/flash_read_cache.sv | 146 ++++++++++++++
 tb/tb_flash_read_cache.sv | 288 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/flash_read_cache_pkg.sv
// Shared constants, types and address-split helpers for the direct-mapped flash read cache.
package flash_read_cache_pkg;

    localparam int LINES          = 64;
    localparam int WORDS_PER_LINE = 4;
    localparam int ADDR_W         = 24;

    localparam int OFF_W = $clog2(WORDS_PER_LINE);
    localparam int IDX_W = $clog2(LINES);
    localparam int TAG_W = ADDR_W - 2 - OFF_W - IDX_W;

    typedef logic [ADDR_W-1:2] word_addr_t;
    typedef logic [OFF_W-1:0]  offset_t;
    typedef logic [IDX_W-1:0]  idx_t;
    typedef logic [TAG_W-1:0]  tag_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOOKUP,
        ST_FILL_AR,
        ST_FILL_R,
        ST_RESP
    } state_t;

    function automatic offset_t addr_offset(input word_addr_t a);
        return a[2 +: OFF_W];
    endfunction

    function automatic idx_t addr_index(input word_addr_t a);
        return a[2 + OFF_W +: IDX_W];
    endfunction

    function automatic tag_t addr_tag(input word_addr_t a);
        return a[ADDR_W-1 -: TAG_W];
    endfunction

    // Rebuilds a word-aligned flash address; bits above the flash window stay zero.
    function automatic logic [31:0] fill_addr(input tag_t tag, input idx_t idx, input offset_t off);
        logic [31:0] a;
        a = '0;
        a[ADDR_W-1:2] = {tag, idx, off};
        return a;
    endfunction

endpackage

// File: rtl/flash_read_cache_if.sv
// Read-only AXI-lite subset (AR and R channels) used on both sides of the cache.
interface flash_read_cache_if;

    logic        arvalid;
    logic        arready;
    logic [31:0] araddr;
    logic [2:0]  arprot;
    logic        rvalid;
    logic        rready;
    logic [31:0] rdata;

    modport master (
        output arvalid, araddr, arprot, rready,
        input  arready, rvalid, rdata
    );

    modport slave (
        input  arvalid, araddr, arprot, rready,
        output arready, rvalid, rdata
    );

endinterface

// File: rtl/flash_read_cache_ram.sv
// 1R1W synchronous data and tag storage; reads are registered so the arrays map onto block RAM.
module flash_read_cache_ram
    import flash_read_cache_pkg::*;
(
    input  logic        clk,
    input  idx_t        rd_idx,
    input  offset_t     rd_off,
    output logic [31:0] rd_data,
    output tag_t        rd_tag,
    input  logic        data_we,
    input  logic        tag_we,
    input  idx_t        wr_idx,
    input  offset_t     wr_off,
    input  logic [31:0] wr_data,
    input  tag_t        wr_tag
);

    logic [31:0] data_mem [LINES*WORDS_PER_LINE];
    tag_t        tag_mem  [LINES];

    always_ff @(posedge clk) begin
        if (data_we) begin
            data_mem[{wr_idx, wr_off}] <= wr_data;
        end
        rd_data <= data_mem[{rd_idx, rd_off}];
    end

    always_ff @(posedge clk) begin
        if (tag_we) begin
            tag_mem[wr_idx] <= wr_tag;
        end
        rd_tag <= tag_mem[rd_idx];
    end

endmodule

// File: rtl/flash_read_cache.sv
// Direct-mapped read-only line cache between the CPU read port and the flash controller.
// Misses fill a whole line with single-word reads before the CPU is answered.
module flash_read_cache
    import flash_read_cache_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    flash_read_cache_if.slave  s_axi,
    flash_read_cache_if.master m_axi,
    input  logic               invalidate
);

    state_t      state, state_nx;
    tag_t        req_tag;
    idx_t        req_idx;
    offset_t     req_off;
    logic [2:0]  req_prot;
    offset_t     fill_cnt;
    logic        fill_poisoned;
    logic [LINES-1:0] valid;
    logic [31:0] rdata_q;
    logic [31:0] ram_rdata;
    tag_t        ram_tag;
    word_addr_t  cpu_word;
    logic        ar_fire;
    logic        hit;
    logic        fill_beat;
    logic        fill_last;
    logic        unused_addr_bits;

    assign cpu_word         = s_axi.araddr[ADDR_W-1:2];
    assign unused_addr_bits = ^{s_axi.araddr[31:ADDR_W], s_axi.araddr[1:0]};

    assign ar_fire   = (state == ST_IDLE) && s_axi.arvalid;
    assign hit       = valid[req_idx] && (ram_tag == req_tag) && !invalidate;
    assign fill_beat = (state == ST_FILL_R) && m_axi.rvalid;
    assign fill_last = fill_beat && (fill_cnt == offset_t'(WORDS_PER_LINE - 1));

    // The RAM is addressed straight from the CPU bus so the lookup data is ready one cycle after the handshake.
    flash_read_cache_ram u_ram (
        .clk     (clk),
        .rd_idx  (addr_index(cpu_word)),
        .rd_off  (addr_offset(cpu_word)),
        .rd_data (ram_rdata),
        .rd_tag  (ram_tag),
        .data_we (fill_beat),
        .tag_we  (fill_last),
        .wr_idx  (req_idx),
        .wr_off  (fill_cnt),
        .wr_data (m_axi.rdata),
        .wr_tag  (req_tag)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx      = state;
        s_axi.arready = 1'b0;
        s_axi.rvalid  = 1'b0;
        m_axi.arvalid = 1'b0;
        m_axi.rready  = 1'b0;
        case (state)
            ST_IDLE: begin
                s_axi.arready = 1'b1;
                if (s_axi.arvalid) begin
                    state_nx = ST_LOOKUP;
                end
            end
            ST_LOOKUP: begin
                state_nx = hit ? ST_RESP : ST_FILL_AR;
            end
            ST_FILL_AR: begin
                m_axi.arvalid = 1'b1;
                if (m_axi.arready) begin
                    state_nx = ST_FILL_R;
                end
            end
            ST_FILL_R: begin
                m_axi.rready = 1'b1;
                if (m_axi.rvalid) begin
                    state_nx = fill_last ? ST_RESP : ST_FILL_AR;
                end
            end
            ST_RESP: begin
                s_axi.rvalid = 1'b1;
                if (s_axi.rready) begin
                    state_nx = ST_IDLE;
                end
            end
            default: state_nx = ST_IDLE;
        endcase
    end

    assign s_axi.rdata  = rdata_q;
    assign m_axi.araddr = fill_addr(req_tag, req_idx, fill_cnt);
    assign m_axi.arprot = req_prot;

    // An invalidate seen at any point of a fill poisons that line so it is returned once but never cached.
    always_ff @(posedge clk) begin
        if (rst) begin
            req_tag       <= '0;
            req_idx       <= '0;
            req_off       <= '0;
            req_prot      <= '0;
            fill_cnt      <= '0;
            fill_poisoned <= 1'b0;
            valid         <= '0;
            rdata_q       <= '0;
        end else begin
            if (ar_fire) begin
                req_tag  <= addr_tag(cpu_word);
                req_idx  <= addr_index(cpu_word);
                req_off  <= addr_offset(cpu_word);
                req_prot <= s_axi.arprot;
            end
            if (state == ST_LOOKUP) begin
                fill_cnt      <= '0;
                fill_poisoned <= 1'b0;
                if (hit) begin
                    rdata_q <= ram_rdata;
                end
            end
            if (fill_beat) begin
                if (fill_cnt == req_off) begin
                    rdata_q <= m_axi.rdata;
                end
                fill_cnt <= fill_cnt + 1'b1;
            end
            if (invalidate) begin
                valid <= '0;
                if (state == ST_FILL_AR || state == ST_FILL_R) begin
                    fill_poisoned <= 1'b1;
                end
            end else if (fill_last && !fill_poisoned) begin
                valid[req_idx] <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_flash_read_cache.sv
// Randomized and directed bench for flash_read_cache against a line-level model of the cache.
module tb_flash_read_cache;
    import flash_read_cache_pkg::*;

    localparam int LINE_BYTES = WORDS_PER_LINE * 4;
    localparam int TIMEOUT    = 200;
    localparam int INV_NONE   = 0;
    localparam int INV_LOOKUP = 1;
    localparam int INV_FILL   = 2;

    logic clk = 1'b0;
    logic rst;
    logic invalidate;

    flash_read_cache_if s_bus ();
    flash_read_cache_if m_bus ();

    flash_read_cache dut (
        .clk        (clk),
        .rst        (rst),
        .s_axi      (s_bus),
        .m_axi      (m_bus),
        .invalidate (invalidate)
    );

    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int          n_pass = 0;
    int          n_checks = 0;
    int          n_fail = 0;
    bit          model_valid [LINES];
    int unsigned model_tag [LINES];
    int unsigned gen = 0;
    logic [31:0] ar_log [$];
    logic [2:0]  prot_log [$];
    int          ar_stall = 0;
    int          overlap_err = 0;

    // Flash contents change with each programming generation so stale hits show up as wrong data.
    function automatic logic [31:0] flash_word(input logic [31:0] a, input int unsigned g);
        return (a * 32'h9E37_79B1) ^ (g * 32'h0101_0101) ^ 32'h5A5A_5A5A;
    endfunction

    task automatic check_output(input string name, input logic [31:0] observed, input logic [31:0] expected);
        n_checks++;
        assert (observed === expected) n_pass++;
        else begin
            n_fail++;
            $error("[TB] FAIL %s: observed %0h, expected %0h", name, observed, expected);
        end
    endtask

    task automatic clear_model();
        foreach (model_valid[i]) model_valid[i] = 1'b0;
    endtask

    task automatic check_reset_outputs(input string name);
        check_output({name, " s_arready"}, s_bus.arready, 1);
        check_output({name, " s_rvalid"},  s_bus.rvalid, 0);
        check_output({name, " s_rdata"},   s_bus.rdata, 0);
        check_output({name, " m_arvalid"}, m_bus.arvalid, 0);
        check_output({name, " m_rready"},  m_bus.rready, 0);
        check_output({name, " m_araddr"},  m_bus.araddr, 0);
        check_output({name, " m_arprot"},  m_bus.arprot, 0);
    endtask

    task automatic pulse_invalidate();
        invalidate = 1'b1;
        @(negedge clk);
        invalidate = 1'b0;
        gen++;
        clear_model();
    endtask

    // Flash controller stand-in: one read at a time, optional AR stall, random R delay.
    initial begin : responder
        bit          pend = 1'b0;
        bit          ar_next = 1'b0;
        bit          r_next = 1'b0;
        logic [31:0] pend_addr = '0;
        int          rdelay = 0;
        m_bus.arready = 1'b0;
        m_bus.rvalid  = 1'b0;
        m_bus.rdata   = '0;
        forever begin
            @(negedge clk);
            #1;
            if (ar_next) begin
                pend   = 1'b1;
                rdelay = $urandom_range(0, 2);
            end
            if (r_next) pend = 1'b0;
            ar_next = 1'b0;
            r_next  = 1'b0;
            m_bus.arready = 1'b0;
            m_bus.rvalid  = 1'b0;
            if (rst) begin
                pend = 1'b0;
            end else begin
                if (m_bus.arvalid) begin
                    if (pend) overlap_err++;
                    else if (ar_stall > 0) ar_stall--;
                    else begin
                        m_bus.arready = 1'b1;
                        ar_next   = 1'b1;
                        pend_addr = m_bus.araddr;
                        ar_log.push_back(m_bus.araddr);
                        prot_log.push_back(m_bus.arprot);
                    end
                end
                if (pend) begin
                    if (rdelay > 0) rdelay--;
                    else begin
                        m_bus.rvalid = 1'b1;
                        m_bus.rdata  = flash_word(pend_addr, gen);
                        if (m_bus.rready) r_next = 1'b1;
                    end
                end
            end
        end
    end

    // One complete CPU read: handshake, wait for data, optional rready hold, and model update.
    task automatic apply_stimulus(input string name, input logic [31:0] addr, input logic [2:0] prot,
                                  input int hold, input int inv_mode, output int hs_cycle);
        int unsigned waddr, base, idx, tag;
        bit          exp_hit, inv_done, stable;
        logic [31:0] exp_data;
        int          lat, waited, exp_reads;
        waddr    = addr & ((32'd1 << ADDR_W) - 1);
        waddr    = waddr - (waddr % 4);
        base     = waddr - (waddr % LINE_BYTES);
        idx      = (waddr / LINE_BYTES) % LINES;
        tag      = waddr / (LINE_BYTES * LINES);
        if (inv_mode == INV_LOOKUP) clear_model();
        exp_hit  = model_valid[idx] && (model_tag[idx] == tag);
        exp_data = flash_word(waddr, gen);
        exp_reads = exp_hit ? 0 : WORDS_PER_LINE;
        inv_done = 1'b0;
        ar_log.delete();
        prot_log.delete();

        waited = 0;
        while (s_bus.arready !== 1'b1 && waited < TIMEOUT) begin
            @(negedge clk);
            waited++;
        end
        check_output({name, " arready_idle"}, s_bus.arready, 1);
        s_bus.arvalid = 1'b1;
        s_bus.araddr  = addr;
        s_bus.arprot  = prot;
        @(posedge clk);
        hs_cycle = cyc;
        @(negedge clk);
        s_bus.arvalid = 1'b0;
        s_bus.araddr  = $urandom;
        s_bus.arprot  = 3'($urandom);
        lat = 1;
        if (inv_mode == INV_LOOKUP) invalidate = 1'b1;
        while (s_bus.rvalid !== 1'b1 && lat < TIMEOUT) begin
            @(negedge clk);
            lat++;
            invalidate = 1'b0;
            if (inv_mode == INV_FILL && !inv_done && ar_log.size() == 2) begin
                invalidate = 1'b1;
                inv_done   = 1'b1;
            end
        end
        invalidate = 1'b0;
        check_output({name, " rvalid"}, s_bus.rvalid, 1);
        if (exp_hit) check_output({name, " hit_latency"}, lat, 2);
        check_output({name, " fill_reads"}, ar_log.size(), exp_reads);
        for (int k = 0; k < ar_log.size() && k < WORDS_PER_LINE; k++) begin
            check_output({name, " fill_addr"}, ar_log[k], base + 4 * k);
            check_output({name, " fill_prot"}, prot_log[k], prot);
        end

        stable = 1'b1;
        for (int i = 0; i < hold; i++) begin
            if (s_bus.rvalid !== 1'b1 || s_bus.rdata !== exp_data || s_bus.arready !== 1'b0) stable = 1'b0;
            @(negedge clk);
        end
        if (hold > 0) check_output({name, " hold_stable"}, stable, 1);
        check_output({name, " rdata"}, s_bus.rdata, exp_data);
        s_bus.rready = 1'b1;
        @(negedge clk);
        s_bus.rready = 1'b0;
        check_output({name, " rvalid_drop"}, s_bus.rvalid, 0);
        check_output({name, " no_extra_reads"}, ar_log.size(), exp_reads);

        if (inv_done) clear_model();
        else if (!exp_hit) begin
            model_valid[idx] = 1'b1;
            model_tag[idx]   = tag;
        end
    endtask

    initial begin : main
        logic [31:0] addr;
        int          hs1, hs2, waited, mode;
        bit          stable;
        rst          = 1'b1;
        invalidate   = 1'b0;
        s_bus.arvalid = 1'b0;
        s_bus.araddr  = '0;
        s_bus.arprot  = '0;
        s_bus.rready  = 1'b0;
        clear_model();
        repeat (4) @(negedge clk);
        check_reset_outputs("reset");
        rst = 1'b0;

        apply_stimulus("cold_0x100", 32'h0000_0100, 3'b000, 0, INV_NONE, hs1);
        apply_stimulus("hit_0x108", 32'h0000_0108, 3'b000, 0, INV_NONE, hs1);
        apply_stimulus("hit_0x10C", 32'h0000_010C, 3'b000, 0, INV_NONE, hs2);
        check_output("b2b_hit_spacing", hs2 - hs1, 3);

        apply_stimulus("evict_a", 32'h0000_0100, 3'b000, 0, INV_NONE, hs1);
        apply_stimulus("evict_b", 32'h0000_0100 + LINES * LINE_BYTES, 3'b011, 0, INV_NONE, hs1);
        apply_stimulus("evict_a_again", 32'h0000_0100, 3'b000, 0, INV_NONE, hs1);
        apply_stimulus("prot_ignored", 32'h0000_0104, 3'b111, 0, INV_NONE, hs1);

        pulse_invalidate();
        apply_stimulus("refill_after_inv", 32'h0000_0100, 3'b001, 0, INV_NONE, hs1);
        apply_stimulus("inv_in_lookup", 32'h0000_0100, 3'b000, 0, INV_LOOKUP, hs1);
        apply_stimulus("hit_after_lookup_inv", 32'h0000_0100, 3'b000, 0, INV_NONE, hs1);
        apply_stimulus("inv_mid_fill", 32'h0000_0208, 3'b100, 0, INV_FILL, hs1);
        apply_stimulus("miss_after_mid_fill", 32'h0000_0208, 3'b100, 0, INV_NONE, hs1);

        apply_stimulus("hold_hit", 32'h0000_0204, 3'b000, 10, INV_NONE, hs1);
        apply_stimulus("hold_miss", 32'h0000_0300, 3'b010, 10, INV_NONE, hs1);
        apply_stimulus("upper_bits", 32'hAB00_0302, 3'b000, 0, INV_NONE, hs1);

        // AR stall then reset part-way through the fill.
        ar_stall = 8;
        ar_log.delete();
        s_bus.arvalid = 1'b1;
        s_bus.araddr  = 32'h0000_0400;
        s_bus.arprot  = 3'b010;
        @(posedge clk);
        @(negedge clk);
        s_bus.arvalid = 1'b0;
        waited = 0;
        while (m_bus.arvalid !== 1'b1 && waited < TIMEOUT) begin
            @(negedge clk);
            waited++;
        end
        stable = 1'b1;
        for (int i = 0; i < 5; i++) begin
            if (m_bus.arvalid !== 1'b1 || m_bus.araddr !== 32'h0000_0400 || m_bus.arprot !== 3'b010) stable = 1'b0;
            @(negedge clk);
        end
        check_output("stall_addr_stable", stable, 1);
        check_output("stall_no_fire", ar_log.size(), 0);
        rst = 1'b1;
        @(negedge clk);
        check_reset_outputs("rst_mid_fill");
        rst = 1'b0;
        ar_stall = 0;
        clear_model();
        apply_stimulus("miss_after_reset", 32'h0000_0100, 3'b000, 0, INV_NONE, hs1);

        for (int n = 0; n < 40; n++) begin
            addr = $urandom_range(0, 2) * LINES * LINE_BYTES + $urandom_range(0, 3) * LINE_BYTES
                 + $urandom_range(0, WORDS_PER_LINE - 1) * 4 + $urandom_range(0, 3);
            if ($urandom_range(0, 3) == 0) addr = addr | ($urandom << ADDR_W);
            if ($urandom_range(0, 7) == 0) pulse_invalidate();
            mode = $urandom_range(0, 9);
            mode = (mode == 0) ? INV_LOOKUP : (mode == 1) ? INV_FILL : INV_NONE;
            ar_stall = $urandom_range(0, 2);
            apply_stimulus("random", addr, 3'($urandom), $urandom_range(0, 3), mode, hs1);
        end

        check_output("single_outstanding", overlap_err, 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin : watchdog
        #500000;
        $display("[TB] FAIL watchdog: simulation did not complete, observed timeout, expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
